// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// pc_unit : fetch PC register, next-PC select and circular return-address stack
// rev 1.0
// ============================================================================
module pc_unit #(
   parameter int          ADDR_W      = 64,
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter int          INSTR_SHIFT = 2,
   parameter int          RAS_DEPTH   = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         stall,
   input  logic                         redirect_valid,
   input  logic [ADDR_W-1:0]            redirect_pc,
   input  logic                         br_taken,
   input  logic                         uncond_br,
   input  logic [18:0]                  cond_addr19,
   input  logic [25:0]                  br_addr26,
   input  logic                         is_call,
   input  logic                         is_ret,
   input  logic [ADDR_W-1:0]            ret_reg,
   output logic [ADDR_W-1:0]            pc,
   output logic [ADDR_W-1:0]            pc_seq,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_used
);

   localparam int                PTR_W      = $clog2(RAS_DEPTH);
   localparam int                CNT_W      = PTR_W + 1;
   localparam logic [ADDR_W-1:0] c_incr     = ADDR_W'(1) << INSTR_SHIFT;
   localparam logic [ADDR_W-1:0] c_reset_pc = RESET_PC[ADDR_W-1:0];
   localparam logic [CNT_W-1:0]  c_full     = CNT_W'(RAS_DEPTH);

   logic [ADDR_W-1:0] r_pc;
   logic [PTR_W-1:0]  r_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

   logic [ADDR_W-1:0] w_seq;
   logic [ADDR_W-1:0] w_off19;
   logic [ADDR_W-1:0] w_off26;
   logic [ADDR_W-1:0] w_br_target;
   logic [ADDR_W-1:0] w_ret_target;
   logic [ADDR_W-1:0] w_next_pc;
   logic [PTR_W-1:0]  w_top_idx;
   logic              w_nonempty;
   logic              w_active;
   logic              w_push;
   logic              w_pop;
   logic              w_replace;

   // r_ptr names the next free slot; the top of stack sits one below it
   assign w_top_idx    = r_ptr - PTR_W'(1);
   assign w_nonempty   = (r_count != '0);
   assign w_active     = ~stall & ~redirect_valid;

   assign w_seq        = r_pc + c_incr;
   assign w_off19      = {{(ADDR_W-19){cond_addr19[18]}}, cond_addr19} << INSTR_SHIFT;
   assign w_off26      = {{(ADDR_W-26){br_addr26[25]}}, br_addr26} << INSTR_SHIFT;
   assign w_br_target  = r_pc + (uncond_br ? w_off26 : w_off19);
   assign w_ret_target = w_nonempty ? r_ras[w_top_idx] : ret_reg;

   assign w_push       = is_call & br_taken & w_active;
   assign w_pop        = is_ret & w_active & w_nonempty;
   // call and return together: top entry is swapped in place, depth unchanged
   assign w_replace    = w_push & w_pop;

   always_comb begin
      w_next_pc = w_seq;
      if (redirect_valid) begin
         w_next_pc = redirect_pc;
      end else if (stall) begin
         w_next_pc = r_pc;
      end else if (is_ret) begin
         w_next_pc = w_ret_target;
      end else if (br_taken) begin
         w_next_pc = w_br_target;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc <= c_reset_pc;
      end else begin
         r_pc <= w_next_pc;
      end
   end

   // full stack pushes wrap onto the oldest slot; count saturates at depth
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr   <= '0;
         r_count <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            r_ras[i] <= '0;
         end
      end else if (w_replace) begin
         r_ras[w_top_idx] <= w_seq;
      end else if (w_push) begin
         r_ras[r_ptr] <= w_seq;
         r_ptr        <= r_ptr + PTR_W'(1);
         if (r_count != c_full) begin
            r_count <= r_count + CNT_W'(1);
         end
      end else if (w_pop) begin
         r_ptr   <= r_ptr - PTR_W'(1);
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign pc        = r_pc;
   assign pc_seq    = w_seq;
   assign ras_count = r_count;
   assign ras_used  = is_ret & w_nonempty & w_active;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// tb_pc_unit : directed and random checks of pc_unit against a queue-based model
// rev 1.0
// ============================================================================
module tb_pc_unit;

   logic        clk;
   logic        reset_n;
   logic        stall;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        br_taken;
   logic        uncond_br;
   logic [18:0] cond_addr19;
   logic [25:0] br_addr26;
   logic        is_call;
   logic        is_ret;
   logic [63:0] ret_reg;
   logic [63:0] pc;
   logic [63:0] pc_seq;
   logic [2:0]  ras_count;
   logic        ras_used;

   int checks = 0;
   int errors = 0;

   logic [63:0] m_pc;
   logic [63:0] m_ras [$];

   pc_unit #(
      .ADDR_W      (64),
      .RESET_PC    (64'h0),
      .INSTR_SHIFT (2),
      .RAS_DEPTH   (4)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .br_taken       (br_taken),
      .uncond_br      (uncond_br),
      .cond_addr19    (cond_addr19),
      .br_addr26      (br_addr26),
      .is_call        (is_call),
      .is_ret         (is_ret),
      .ret_reg        (ret_reg),
      .pc             (pc),
      .pc_seq         (pc_seq),
      .ras_count      (ras_count),
      .ras_used       (ras_used)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      stall = 0; redirect_valid = 0; redirect_pc = '0; br_taken = 0; uncond_br = 0;
      cond_addr19 = '0; br_addr26 = '0; is_call = 0; is_ret = 0; ret_reg = '0;
   endtask

   // Reference: the stack is a queue whose back is the top; at most 4 kept.
   task automatic model_next();
      logic [63:0]        seq, tgt, rt;
      logic signed [63:0] off;
      bit                 act;
      seq = m_pc + 64'd4;
      if (uncond_br) off = $signed(br_addr26);
      else           off = $signed(cond_addr19);
      tgt = m_pc + off * 4;
      rt  = (m_ras.size() > 0) ? m_ras[$] : ret_reg;
      act = !stall && !redirect_valid;
      if (redirect_valid)  m_pc = redirect_pc;
      else if (!stall)     m_pc = is_ret ? rt : (br_taken ? tgt : seq);
      if (act) begin
         if (is_ret && m_ras.size() > 0) void'(m_ras.pop_back());
         if (is_call && br_taken) begin
            m_ras.push_back(seq);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
         end
      end
   endtask

   // Inputs are already applied; check combinational outputs, clock once, check state.
   task automatic step();
      logic exp_used;
      #1;
      exp_used = is_ret && (m_ras.size() > 0) && !stall && !redirect_valid;
      chk("pc_seq", pc_seq, m_pc + 64'd4);
      chk("ras_used", {63'b0, ras_used}, {63'b0, exp_used});
      model_next();
      @(posedge clk);
      #1;
      chk("pc", pc, m_pc);
      chk("ras_count", {61'b0, ras_count}, 64'(m_ras.size()));
   endtask

   task automatic go_to(input logic [63:0] target);
      idle(); redirect_valid = 1; redirect_pc = target;
      step();
      idle();
   endtask

   task automatic call_uncond(input logic [25:0] off);
      idle(); is_call = 1; br_taken = 1; uncond_br = 1; br_addr26 = off;
      step();
      idle();
   endtask

   initial begin
      idle();
      reset_n = 0;
      m_pc = 64'h0;
      #1;
      chk("reset_pc", pc, 64'h0);
      chk("reset_ras_count", {61'b0, ras_count}, 64'h0);
      chk("reset_pc_seq", pc_seq, 64'h4);
      @(negedge clk);
      reset_n = 1;

      // sequential fetch after reset
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("seq_pc", pc, 64'(i * 4));
      end

      // conditional and unconditional branch offsets
      go_to(64'h100);
      br_taken = 1; uncond_br = 0; cond_addr19 = 19'h7FFFE;
      step();
      chk("cond_back", pc, 64'hF8);
      go_to(64'h100);
      br_taken = 1; uncond_br = 1; br_addr26 = 26'h10;
      step();
      chk("uncond_fwd", pc, 64'h140);
      idle(); br_taken = 1; uncond_br = 1; br_addr26 = 26'h3FFFFFF;
      step();
      chk("uncond_back", pc, 64'h13C);

      // call then return via RAS, then return via ret_reg
      go_to(64'h200);
      call_uncond(26'h40);
      chk("call_pc", pc, 64'h300);
      chk("call_cnt", {61'b0, ras_count}, 64'd1);
      step();
      is_ret = 1; ret_reg = 64'hDEAD;
      #1 chk("ret_used", {63'b0, ras_used}, 64'd1);
      step();
      chk("ret_pc", pc, 64'h204);
      is_ret = 1; ret_reg = 64'hDEAD;
      step();
      chk("ret_empty_pc", pc, 64'hDEAD);
      idle();

      // five nested calls into a 4-deep stack
      for (int i = 1; i <= 5; i++) begin
         go_to(64'(i * 16));
         call_uncond(26'h100);
      end
      chk("sat_cnt", {61'b0, ras_count}, 64'd4);
      for (int i = 5; i >= 1; i--) begin
         idle(); is_ret = 1; ret_reg = 64'hBEEF;
         step();
         chk("nested_ret", pc, (i > 1) ? 64'(i * 16 + 4) : 64'hBEEF);
      end
      idle();

      // simultaneous call and return on empty then non-empty stack
      go_to(64'h500);
      is_call = 1; is_ret = 1; br_taken = 1; ret_reg = 64'h600;
      step();
      chk("callret_empty_pc", pc, 64'h600);
      is_call = 1; is_ret = 1; br_taken = 1; ret_reg = 64'h700;
      step();
      chk("callret_top_pc", pc, 64'h504);
      chk("callret_cnt", {61'b0, ras_count}, 64'd1);
      idle();

      // stall blocks everything; redirect overrides stall
      go_to(64'h900);
      stall = 1; br_taken = 1; is_call = 1; uncond_br = 1; br_addr26 = 26'h20;
      step();
      chk("stall_pc", pc, 64'h900);
      redirect_valid = 1; redirect_pc = 64'h8000;
      step();
      chk("redir_pc", pc, 64'h8000);
      chk("redir_cnt", {61'b0, ras_count}, 64'd1);
      idle();

      // no push when is_call lacks br_taken
      is_call = 1;
      step();
      idle();

      // wrap-around and asynchronous reset between edges
      call_uncond(26'h4);
      go_to(64'hFFFF_FFFF_FFFF_FFFC);
      step();
      chk("wrap_pc", pc, 64'h0);
      step();
      #2 reset_n = 0;
      #1;
      chk("async_rst_pc", pc, 64'h0);
      chk("async_rst_cnt", {61'b0, ras_count}, 64'h0);
      m_pc = 64'h0;
      m_ras.delete();
      #1 reset_n = 1;
      step();

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         idle();
         redirect_valid = ($urandom_range(15) == 0);
         redirect_pc    = {$urandom, $urandom};
         stall          = ($urandom_range(7) == 0);
         br_taken       = $urandom_range(1);
         uncond_br      = $urandom_range(1);
         cond_addr19    = 19'($urandom);
         br_addr26      = 26'($urandom);
         is_call        = ($urandom_range(3) == 0);
         is_ret         = ($urandom_range(3) == 0);
         ret_reg        = {$urandom, $urandom};
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised next-PC generator and PC register for the single-clock 64-bit pipeline. It holds the architectural fetch PC and selects the next PC from these sources: sequential, conditional branch (19-bit offset), unconditional branch (26-bit offset), return (RAS-predicted or register), and external redirect. It adds stall and redirect control and a circular return-address stack (RAS) for call/return pairs. It sits at the head of fetch and feeds the instruction memory address.

Parameters:
ADDR_W, 64, width of PC and all address arithmetic
RESET_PC, 64'h0, PC value loaded on reset (truncated to ADDR_W)
INSTR_SHIFT, 2, left-shift applied to branch offsets; sequential increment is 1<<INSTR_SHIFT
RAS_DEPTH, 4, number of RAS entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
stall  in  1  hold PC and RAS this cycle
redirect_valid  in  1  force next PC to redirect_pc (flush/exception)
redirect_pc  in  ADDR_W  redirect target
br_taken  in  1  take branch target this cycle
uncond_br  in  1  1 selects br_addr26, 0 selects cond_addr19
cond_addr19  in  19  signed word offset, conditional branch
br_addr26  in  26  signed word offset, unconditional branch
is_call  in  1  branch-and-link: push return address
is_ret  in  1  return instruction
ret_reg  in  ADDR_W  register-file return address (fallback)
pc  out  ADDR_W  current fetch PC
pc_seq  out  ADDR_W  pc + (1<<INSTR_SHIFT), combinational
ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_used  out  1  combinational: this cycle's return target came from RAS

Behaviour:
- Reset (async, reset_n=0): pc=RESET_PC, ras_count=0, RAS pointer=0, RAS entries=0. Release is synchronous to the next clk edge. pc_seq and ras_used follow combinationally.
- Arithmetic: offset = sign-extend(selected field to ADDR_W) << INSTR_SHIFT. br_target = pc + offset. pc_seq = pc + (1<<INSTR_SHIFT). All arithmetic is modulo 2^ADDR_W; wrap is silent, with no flag.
- ret_target = RAS top if ras_count>0, else ret_reg. ras_used = is_ret & ras_count>0 & ~stall & ~redirect_valid.
- Next-PC priority, one-cycle latency (pc updates on the clk edge after the inputs are presented):
  1. redirect_valid: pc<=redirect_pc. RAS unchanged. Overrides stall.
  2. stall: pc holds. No RAS push or pop.
  3. is_ret: pc<=ret_target. br_taken and uncond_br are ignored.
  4. br_taken: pc<=br_target.
  5. else: pc<=pc_seq.
- RAS push: is_call & br_taken & ~stall & ~redirect_valid writes pc_seq at the top.
  - Full (ras_count==RAS_DEPTH): the oldest entry is overwritten (circular) and ras_count saturates.
- RAS pop: is_ret & ~stall & ~redirect_valid & ras_count>0 decrements the pointer. Popping when empty is a no-op and ret_reg is used.
- Simultaneous call and ret (is_call & is_ret & br_taken): pc<=ret_target, then the top entry is replaced by pc_seq. ras_count is unchanged, or becomes 1 if it was 0.
- is_call without br_taken: no push.
- Reset mid-operation: the state above is restored immediately regardless of clk. In-flight RAS contents are discarded.

Test Plan:
1. Reset then 3 idle cycles, RESET_PC=0 -> pc = 0, 4, 8, 12. ras_count=0 throughout.
2. pc=0x100, br_taken=1, uncond_br=0, cond_addr19=19'h7FFFE (-2) -> next pc=0xF8. Same with uncond_br=1, br_addr26=26'h10 -> next pc=0x140.
3. pc=0x200, call (is_call=1, br_taken=1, uncond_br=1, br_addr26=0x40) -> pc=0x300, ras_count=1. Later is_ret with ret_reg=0xDEAD -> pc=0x204, ras_used=1, ras_count=0. A second is_ret -> pc=0xDEAD, ras_used=0.
4. Five nested calls from pcs 0x10, 0x20, 0x30, 0x40, 0x50 with RAS_DEPTH=4 -> ras_count saturates at 4. Five returns yield 0x54, 0x44, 0x34, 0x24, then ret_reg.
5. stall=1 with br_taken and is_call asserted -> pc and ras_count unchanged. Same cycle with redirect_valid=1, redirect_pc=0x8000 -> pc=0x8000, RAS unchanged.
6. pc=64'hFFFF_FFFF_FFFF_FFFC, idle -> pc wraps to 0. Assert reset_n=0 mid-cycle between edges -> pc=RESET_PC and ras_count=0 before the next clk edge.
